rr_decode_sched: RTL and testbench



---
 rtl/rr_decode_sched_pkg.sv | 13 +
 rtl/rr_pick4.sv | 21 ++
 rtl/rr_decode_sched.sv | 76 +++++++
 tb/tb_rr_decode_sched.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rr_decode_sched_pkg.sv
// rr_decode_sched_pkg: shared FSM state encoding and default hold limit.
package rr_decode_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int MAX_HOLD_DEF = 16;
    localparam int CNT_W_DEF    = 8;

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: rotate-priority picker; searches req starting just after last, wrapping 3->0.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] pick,
    output logic       any
);

    // Walk from farthest to nearest so the nearest set bit after last wins.
    always_comb begin
        pick = last;
        any  = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            if (req[2'(last + 2'(i))]) begin
                pick = 2'(last + 2'(i));
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_decode_sched.sv
// rr_decode_sched: round-robin owner of the shared 2-to-4 decoder select, with hold
// timeout and a one-cycle break-before-make gap between owners.
module rr_decode_sched
    import rr_decode_sched_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       sel_a,
    output logic       sel_b,
    output logic       timeout
);

    state_t           state;
    logic [1:0]       last;
    logic [CNT_W-1:0] hold_cnt;
    logic [1:0]       pick;
    logic             any;

    rr_pick4 u_pick (
        .req  (req),
        .last (last),
        .pick (pick),
        .any  (any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gnt       <= 4'b0;
            gnt_idx   <= 2'd3;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
            last      <= 2'd3;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE, ST_GAP: begin
                    if (any) begin
                        state     <= ST_GRANT;
                        gnt_idx   <= pick;
                        gnt       <= 4'b1 << pick;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    // Release always passes through GAP, even if others are waiting.
                    if (!req[gnt_idx] || hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
                        state     <= ST_GAP;
                        gnt       <= 4'b0;
                        gnt_valid <= 1'b0;
                        last      <= gnt_idx;
                        timeout   <= req[gnt_idx];
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign sel_a = gnt_idx[1];
    assign sel_b = gnt_idx[0];

endmodule

// File: tb/tb_rr_decode_sched.sv
// tb_rr_decode_sched: directed tables, corner sequences and random traffic against a
// cycle-level owner/pointer reference model.
module tb_rr_decode_sched;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid, sel_a, sel_b, timeout;

    rr_decode_sched #(.MAX_HOLD(MH), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference: who owns, how many cycles it has owned, last released owner.
    int m_owner, m_run, m_last, m_idx;
    bit m_to;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_run   = 0;
        m_last  = 3;
        m_idx   = 3;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r);
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner] || m_run == MH) begin
                m_to    = r[m_owner] && m_run == MH;
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_run++;
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                if (r[(m_last + k) % 4]) begin
                    m_owner = (m_last + k) % 4;
                    m_idx   = m_owner;
                    m_run   = 1;
                    break;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_gnt"}, gnt, m_owner >= 0 ? (1 << m_owner) : 0);
        chk({tag, "_idx"}, gnt_idx, m_idx);
        chk({tag, "_valid"}, gnt_valid, m_owner >= 0 ? 1 : 0);
        chk({tag, "_sel_a"}, sel_a, (m_idx >> 1) & 1);
        chk({tag, "_sel_b"}, sel_b, m_idx & 1);
        chk({tag, "_timeout"}, timeout, m_to);
    endtask

    task automatic tick(input logic [3:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] r;
        logic [3:0] g;
        logic [1:0] idx;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic [3:0] rr;
        tbl[0]  = '{4'b1111, 4'b0001, 2'd0};
        tbl[1]  = '{4'b1111, 4'b0001, 2'd0};
        tbl[2]  = '{4'b1111, 4'b0001, 2'd0};
        tbl[3]  = '{4'b1110, 4'b0000, 2'd0};
        tbl[4]  = '{4'b1111, 4'b0010, 2'd1};
        tbl[5]  = '{4'b1111, 4'b0010, 2'd1};
        tbl[6]  = '{4'b1111, 4'b0010, 2'd1};
        tbl[7]  = '{4'b1101, 4'b0000, 2'd1};
        tbl[8]  = '{4'b1111, 4'b0100, 2'd2};
        tbl[9]  = '{4'b1111, 4'b0100, 2'd2};
        tbl[10] = '{4'b1111, 4'b0100, 2'd2};
        tbl[11] = '{4'b1011, 4'b0000, 2'd2};
        tbl[12] = '{4'b1111, 4'b1000, 2'd3};
        tbl[13] = '{4'b1111, 4'b1000, 2'd3};
        tbl[14] = '{4'b1111, 4'b1000, 2'd3};
        tbl[15] = '{4'b0111, 4'b0000, 2'd3};
        tbl[16] = '{4'b1111, 4'b0001, 2'd0};
        tbl[17] = '{4'b0000, 4'b0000, 2'd0};

        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_idx", gnt_idx, 3);
        chk("rst_sel", {sel_a, sel_b}, 3);
        chk("rst_valid", gnt_valid, 0);
        chk("rst_timeout", timeout, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            tick(tbl[i].r, "rot");
            chk($sformatf("rot%0d_gnt", i), gnt, tbl[i].g);
            chk($sformatf("rot%0d_idx", i), gnt_idx, tbl[i].idx);
            chk($sformatf("rot%0d_valid", i), gnt_valid, tbl[i].g != 0);
        end

        for (int i = 0; i < 10; i++) begin
            tick(4'b0000, "idle");
            chk("idle_valid", gnt_valid, 0);
            chk("idle_idx", gnt_idx, 0);
        end

        for (int i = 0; i < 6; i++) begin
            tick(4'b0100, "to");
            chk($sformatf("to%0d_gnt", i), gnt, i == 4 ? 0 : 4);
            chk($sformatf("to%0d_timeout", i), timeout, i == 4 ? 1 : 0);
        end
        tick(4'b0000, "to_rel");

        do_reset();
        for (int i = 0; i < 11; i++) begin
            tick(4'b0101, "fair");
            chk($sformatf("fair%0d_gnt", i), gnt,
                i % 5 == 4 ? 0 : (i < 5 ? 1 : (i < 10 ? 4 : 1)));
            chk($sformatf("fair%0d_timeout", i), timeout, i % 5 == 4 ? 1 : 0);
        end

        do_reset();
        tick(4'b1001, "wrap");
        chk("wrap_last3", gnt, 4'b0001);
        tick(4'b1000, "wrap");
        chk("wrap_gap", gnt, 0);
        tick(4'b1001, "wrap");
        chk("wrap_last0", gnt, 4'b1000);

        tick(4'b1111, "mid");
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_gnt", gnt, 0);
        chk("async_idx", gnt_idx, 3);
        chk("async_timeout", timeout, 0);
        chk("async_valid", gnt_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(4'b1111, "post_rst");
        chk("post_rst_gnt", gnt, 4'b0001);

        rr = 4'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) rr = 4'($urandom);
            tick(rr, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
